// File: rtl/fb_read_scheduler.sv
// Read-port scheduler for the address-chained framebuffer BRAM: shares the single
// read port between the frame scanout stream and a random-access host readback port.
module fb_read_scheduler #(
    parameter int ADDR_BITS    = 10,
    parameter int FRAME_PIXELS = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 frame_done,
    output logic [15:0]          px_data,
    output logic                 px_valid,
    input  logic                 px_ready,
    input  logic                 host_req,
    input  logic [ADDR_BITS-1:0] host_addr,
    output logic                 host_ack,
    output logic [15:0]          host_rdata,
    output logic                 host_rvalid,
    output logic [ADDR_BITS-1:0] bram_raddr,
    output logic                 bram_ren,
    input  logic [15:0]          bram_rdata
);

    // One extra bit so a full 2**ADDR_BITS frame can be counted.
    localparam int CW = ADDR_BITS + 1;
    localparam logic [CW-1:0] FP_C = CW'(FRAME_PIXELS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    typedef enum logic {
        REQ_SCAN = 1'b0,
        REQ_HOST = 1'b1
    } req_t;

    state_t                 state;
    state_t                 state_nx;
    req_t                   cur_req;
    req_t                   last_req;
    logic [CW-1:0]          scan_cnt;
    logic [CW-1:0]          acc_cnt;
    logic [15:0]            fifo_mem [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             fifo_cnt;

    logic                   start_acc;
    logic                   scan_inflight;
    logic                   host_inflight;
    logic [1:0]             occ;
    logic                   scan_elig;
    logic                   host_elig;
    logic                   grant;
    logic                   win_scan;
    logic                   push;
    logic                   pop;
    logic [ADDR_BITS-1:0]   scan_addr;

    // Requester eligibility and round-robin arbitration.
    always_comb begin
        start_acc     = start && !busy && !frame_done;
        scan_inflight = (state != IDLE) && (cur_req == REQ_SCAN);
        host_inflight = (state != IDLE) && (cur_req == REQ_HOST);
        occ           = fifo_cnt + {1'b0, scan_inflight};
        scan_elig     = start_acc || (busy && (scan_cnt < FP_C) && (occ < 2'd2));
        host_elig     = host_req && !host_inflight;
        grant         = (state != ISSUE) && (scan_elig || host_elig);
        win_scan      = scan_elig && (!host_elig || (last_req == REQ_HOST));
        scan_addr     = start_acc ? '0 : scan_cnt[ADDR_BITS-1:0];
        push          = (state == CAPTURE) && (cur_req == REQ_SCAN);
        pop           = (fifo_cnt != 2'd0) && px_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = grant ? ISSUE : IDLE;
            ISSUE:   state_nx = CAPTURE;
            CAPTURE: state_nx = grant ? ISSUE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bram_ren = (state == ISSUE) || (state == CAPTURE);
    end

    // Grant bookkeeping; the address register only moves on a grant, so it
    // stays stable through CAPTURE and while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_req    <= REQ_SCAN;
            last_req   <= REQ_HOST;
            bram_raddr <= '0;
            scan_cnt   <= '0;
            host_ack   <= 1'b0;
        end else begin
            host_ack <= grant && !win_scan;
            if (grant) begin
                cur_req    <= win_scan ? REQ_SCAN : REQ_HOST;
                last_req   <= win_scan ? REQ_SCAN : REQ_HOST;
                bram_raddr <= win_scan ? scan_addr : host_addr;
            end
            if (start_acc) begin
                scan_cnt <= (grant && win_scan) ? CW'(1) : '0;
            end else if (grant && win_scan) begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            host_rvalid <= (state == CAPTURE) && (cur_req == REQ_HOST);
            if ((state == CAPTURE) && (cur_req == REQ_HOST)) begin
                host_rdata <= bram_rdata;
            end
        end
    end

    // Frame completion is detected from the registered accept count, so
    // frame_done lands one cycle after the count reaches the frame size.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            frame_done <= 1'b0;
            acc_cnt    <= '0;
        end else begin
            frame_done <= 1'b0;
            if (start_acc) begin
                busy    <= 1'b1;
                acc_cnt <= '0;
            end else if (busy && (acc_cnt == FP_C)) begin
                busy       <= 1'b0;
                frame_done <= 1'b1;
            end else if (pop) begin
                acc_cnt <= acc_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= bram_rdata;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    always_comb begin
        px_valid = (fifo_cnt != 2'd0);
        px_data  = fifo_mem[rd_ptr];
    end

endmodule

// File: tb/tb_fb_read_scheduler.sv
// Scoreboard bench for fb_read_scheduler: directed frames and host reads against a
// synchronous RAM model holding 0x1000+address.
module tb_fb_read_scheduler;

    localparam int AB = 10;
    localparam int FP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          px_ready = 1'b0;
    logic          host_req = 1'b0;
    logic [AB-1:0] host_addr = '0;
    logic          busy;
    logic          frame_done;
    logic [15:0]   px_data;
    logic          px_valid;
    logic          host_ack;
    logic [15:0]   host_rdata;
    logic          host_rvalid;
    logic [AB-1:0] bram_raddr;
    logic          bram_ren;
    logic [15:0]   bram_rdata = '0;

    logic [15:0]   ram [1 << AB];
    logic [15:0]   px_q [$];
    logic [15:0]   host_q [$];
    int            cyc = 0;
    int            n_pass = 0;
    int            n_total = 0;

    fb_read_scheduler #(.ADDR_BITS(AB), .FRAME_PIXELS(FP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .frame_done(frame_done),
        .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
        .host_req(host_req), .host_addr(host_addr), .host_ack(host_ack),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .bram_raddr(bram_raddr), .bram_ren(bram_ren), .bram_rdata(bram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bram_ren) bram_rdata <= ram[bram_raddr];
    end

    initial begin
        for (int i = 0; i < (1 << AB); i++) ram[i] = 16'(32'h1000 + i);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pops the scoreboard whenever the DUT hands over a pixel or host word.
    always @(negedge clk) begin
        if (px_valid === 1'b1 && px_ready) begin
            if (px_q.size() == 0) check("px_unexpected", 1, 0);
            else check("px_data", px_data, px_q.pop_front());
        end
        if (host_rvalid === 1'b1) begin
            if (host_q.size() == 0) check("host_unexpected", 1, 0);
            else check("host_rdata", host_rdata, host_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_px_valid"}, px_valid, 0);
        check({tag, "_px_data"}, px_data, 0);
        check({tag, "_host_ack"}, host_ack, 0);
        check({tag, "_host_rvalid"}, host_rvalid, 0);
        check({tag, "_host_rdata"}, host_rdata, 0);
        check({tag, "_bram_ren"}, bram_ren, 0);
        check({tag, "_bram_raddr"}, bram_raddr, 0);
    endtask

    task automatic push_frame();
        for (int i = 0; i < FP; i++) px_q.push_back(16'(32'h1000 + i));
    endtask

    // Called right after a tick; t0 is the cycle in which start is high.
    task automatic pulse_start(output int t0);
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic run_frame(input int budget, output int first_pv, output int fd_cyc, output int fd_cnt);
        first_pv = -1;
        fd_cyc = -1;
        fd_cnt = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (px_valid && first_pv < 0) first_pv = cyc;
            if (frame_done) begin
                fd_cnt++;
                if (fd_cyc < 0) fd_cyc = cyc;
            end
        end
        tick();
    endtask

    // Host read issued in the current cycle R; ack must land in R+kmin..R+kmax.
    task automatic host_read(input logic [AB-1:0] a, input int kmin, input int kmax, input string tag);
        int  k;
        bit  got;
        host_q.push_back(ram[a]);
        host_addr = a;
        host_req = 1'b1;
        got = 1'b0;
        for (k = 0; k <= kmax + 2; k++) begin
            @(negedge clk);
            if (host_ack) begin
                got = 1'b1;
                break;
            end
        end
        host_req = 1'b0;
        check({tag, "_ack_window"}, {31'd0, got && k >= kmin && k <= kmax}, 1);
        check({tag, "_raddr_issue"}, bram_raddr, a);
        @(negedge clk);
        check({tag, "_raddr_capture"}, bram_raddr, a);
        check({tag, "_ren_capture"}, bram_ren, 1);
        @(negedge clk);
        check({tag, "_rvalid_a2"}, host_rvalid, 1);
        tick();
    endtask

    initial begin
        int t0, fpv, fdc, fdn, nren, k, nrv, ren_after;
        bit got;

        // Reset and first frame
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("rst");
        tick();
        px_ready = 1'b1;
        push_frame();
        pulse_start(t0);
        run_frame(18, fpv, fdc, fdn);
        check("f1_first_valid", fpv, t0 + 3);
        check("f1_done_cycle", fdc, t0 + 11);
        check("f1_done_pulses", fdn, 1);
        check("f1_busy_after", busy, 0);
        check("f1_all_px", px_q.size(), 0);

        // Downstream stall: only two reads may be outstanding
        px_ready = 1'b0;
        push_frame();
        pulse_start(t0);
        nren = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bram_ren) nren++;
        end
        check("stall_ren_cycles", nren, 4);
        check("stall_px_valid", px_valid, 1);
        check("stall_px_head", px_data, 16'h1000);
        px_ready = 1'b1;
        tick();
        run_frame(20, fpv, fdc, fdn);
        check("stall_done_pulses", fdn, 1);
        check("stall_all_px", px_q.size(), 0);

        // Host reads across the bank boundary, no frame running
        host_read(10'h2FF, 1, 1, "h2ff");
        host_read(10'h300, 1, 1, "h300");
        repeat (3) tick();
        check("host_rdata_hold", host_rdata, 16'h1300);

        // Host reads interleaved with a scan: each tie goes to the host
        px_ready = 1'b1;
        push_frame();
        pulse_start(t0);
        tick();
        host_read(10'h055, 1, 1, "mix1");
        host_read(10'h3AA, 1, 1, "mix2");
        run_frame(30, fpv, fdc, fdn);
        check("mix_done_pulses", fdn, 1);
        check("mix_all_px", px_q.size(), 0);
        check("mix_host_q", host_q.size(), 0);

        // Reset mid-frame with a host read in flight
        push_frame();
        pulse_start(t0);
        tick();
        host_addr = 10'h123;
        host_req = 1'b1;
        got = 1'b0;
        for (k = 0; k < 4; k++) begin
            @(negedge clk);
            if (host_ack) begin
                got = 1'b1;
                break;
            end
        end
        check("abort_ack_seen", {31'd0, got}, 1);
        rst_n = 1'b0;
        host_req = 1'b0;
        tick();
        rst_n = 1'b1;
        px_q.delete();
        @(negedge clk);
        check_reset_vals("abort");
        nrv = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (host_rvalid) nrv++;
        end
        check("abort_no_rvalid", nrv, 0);
        tick();
        push_frame();
        pulse_start(t0);
        run_frame(18, fpv, fdc, fdn);
        check("replay_first_valid", fpv, t0 + 3);
        check("replay_done_cycle", fdc, t0 + 11);
        check("replay_all_px", px_q.size(), 0);

        // start while busy and in the frame_done cycle are both ignored
        push_frame();
        pulse_start(t0);
        fdc = -1;
        fdn = 0;
        ren_after = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (fdc >= 0 && bram_ren) ren_after++;
            if (cyc == t0 + 4) start = 1'b1;
            if (frame_done) begin
                fdn++;
                if (fdc < 0) fdc = cyc;
                start = 1'b1;
            end
        end
        start = 1'b0;
        check("ign_done_cycle", fdc, t0 + 11);
        check("ign_done_pulses", fdn, 1);
        check("ign_busy_after", busy, 0);
        check("ign_no_reads_after", ren_after, 0);
        check("ign_all_px", px_q.size(), 0);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
